acos_taylor: RTL and testbench

- Sequential inverse-cosine unit; the inverse of the cosine block.
- Takes a Q2.14 cosine value and a term count.
- Returns the angle in radians, computed as acos(x) = pi/2 - asin(x), with asin evaluated by a truncated Taylor series.
- Uses a shared multiplier and a controller/datapath split, and the same start/ans_ready handshake as the cosine block, so it can sit directly downstream of that block's output.

---
 rtl/acos_taylor.sv | 167 ++++++++++++++++
 tb/tb_acos_taylor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/acos_taylor.sv
// Sequential inverse cosine: acos(x) = pi/2 - asin(x), with asin(x) from a truncated
// Taylor series in Q2.14, evaluated through one shared multiplier.
module acos_taylor #(
  parameter int MAX_TERMS = 8,
  parameter int FRAC      = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] the_x,
  input  logic [7:0]  the_y,
  output logic [15:0] ans,
  output logic        ans_ready,
  output logic        busy
);

  localparam logic [15:0] PI_2    = 16'd25736;
  localparam logic [15:0] ONE_Q14 = 16'd16384;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQUARE,
    MAC,
    POW,
    FINAL,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        neg_q, neg_d;
  logic [14:0] mag_q, mag_d;
  logic [14:0] x2_q, x2_d;
  logic [14:0] term_q, term_d;
  logic [16:0] acc_q, acc_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] ans_q, ans_d;

  logic [15:0] mulA, mulB;
  logic [31:0] mulP;
  logic [17:0] mulS;
  logic [15:0] coef;
  logic [15:0] magRaw, magClamp;
  logic [3:0]  nClamp;
  logic [16:0] ansSum, ansDiff;

  always_comb begin
    unique case (k_q[2:0])
      3'd0:    coef = 16'd16384;
      3'd1:    coef = 16'd2731;
      3'd2:    coef = 16'd1229;
      3'd3:    coef = 16'd731;
      3'd4:    coef = 16'd498;
      3'd5:    coef = 16'd367;
      3'd6:    coef = 16'd284;
      default: coef = 16'd229;
    endcase
  end

  // One multiplier serves the square, the coefficient MAC and the power step.
  always_comb begin
    mulA = 16'd0;
    mulB = 16'd0;
    case (state_q)
      SQUARE: begin
        mulA = {1'b0, mag_q};
        mulB = {1'b0, mag_q};
      end
      MAC: begin
        mulA = coef;
        mulB = {1'b0, term_q};
      end
      POW: begin
        mulA = {1'b0, term_q};
        mulB = {1'b0, x2_q};
      end
      default: ;
    endcase
  end

  assign mulP = mulA * mulB;
  assign mulS = mulP[31:FRAC];

  // -32768 negates to 0x8000, which still lands above full scale and clamps.
  assign magRaw   = the_x[15] ? (16'd0 - the_x) : the_x;
  assign magClamp = (magRaw > ONE_Q14) ? ONE_Q14 : magRaw;
  assign nClamp   = (the_y > 8'(MAX_TERMS)) ? 4'(MAX_TERMS) : the_y[3:0];
  assign ansSum   = {1'b0, PI_2} + acc_q;
  assign ansDiff  = {1'b0, PI_2} - acc_q;

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    x2_d    = x2_q;
    term_d  = term_q;
    acc_d   = acc_q;
    n_d     = n_q;
    k_d     = k_q;
    ans_d   = ans_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        neg_d   = the_x[15];
        mag_d   = magClamp[14:0];
        n_d     = nClamp;
        term_d  = magClamp[14:0];
        acc_d   = 17'd0;
        k_d     = 4'd0;
        state_d = SQUARE;
      end
      SQUARE: begin
        x2_d    = mulS[14:0];
        state_d = (n_q != 4'd0) ? MAC : FINAL;
      end
      MAC: begin
        acc_d   = acc_q + mulS[16:0];
        state_d = (k_q == 4'(n_q - 4'd1)) ? FINAL : POW;
      end
      POW: begin
        term_d  = mulS[14:0];
        k_d     = k_q + 4'd1;
        state_d = MAC;
      end
      FINAL: begin
        ans_d   = neg_q ? ansSum[15:0] : ansDiff[15:0];
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      x2_q    <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      ans_q   <= '0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      x2_q    <= x2_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      k_q     <= k_d;
      ans_q   <= ans_d;
    end
  end

  assign ans       = ans_q;
  assign ans_ready = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_acos_taylor.sv
// Self-checking bench for acos_taylor: a cycle-timed reference model checked every cycle,
// plus directed operations with hand-computed angles and latencies.
module tb_acos_taylor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] the_x = 16'd0;
  logic [7:0]  the_y = 8'd0;
  logic [15:0] ans;
  logic        ans_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int readyCount = 0;

  acos_taylor #(.MAX_TERMS(8), .FRAC(14)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .the_x(the_x),
    .the_y(the_y),
    .ans(ans),
    .ans_ready(ans_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference: the series written out directly with integer arithmetic.
  function automatic int acosModel(input logic [15:0] x, input logic [7:0] y);
    int coefs[8] = '{16384, 2731, 1229, 731, 498, 367, 284, 229};
    int sx, mag, n, x2, term, acc;
    sx   = int'($signed(x));
    mag  = (sx < 0) ? -sx : sx;
    if (mag > 16384) mag = 16384;
    n    = (y > 8) ? 8 : int'(y);
    x2   = (mag * mag) >> 14;
    term = mag;
    acc  = 0;
    for (int i = 0; i < n; i++) begin
      acc  = acc + ((coefs[i] * term) >> 14);
      term = (term * x2) >> 14;
    end
    return x[15] ? 25736 + acc : 25736 - acc;
  endfunction

  function automatic int latModel(input logic [7:0] y);
    int n;
    n = (y > 8) ? 8 : int'(y);
    return (n == 0) ? 3 : 2 * n + 2;
  endfunction

  // Model timeline: start accepted at edge s, operands taken at s+1, result and
  // ready after s+lat, idle again after s+lat+1.
  int  edgeNo = 0;
  int  opStart = 0;
  int  opLat = 1000;
  int  opAns = 0;
  int  lastAns = 0;
  bit  opActive = 1'b0;

  always @(posedge clk) begin
    int phase;
    int expAns;
    bit expBusy, expReady;
    edgeNo++;
    if (!rst) begin
      opActive = 1'b0;
      lastAns  = 0;
    end else if (!opActive) begin
      if (start) begin
        opActive = 1'b1;
        opStart  = edgeNo;
        opLat    = 1000;
      end
    end else begin
      if (edgeNo == opStart + 1) begin
        opAns = acosModel(the_x, the_y);
        opLat = latModel(the_y);
      end
      if (edgeNo == opStart + opLat + 1) begin
        opActive = 1'b0;
        lastAns  = opAns;
      end
    end
    #3;
    phase    = edgeNo - opStart;
    expBusy  = opActive && (phase <= opLat);
    expReady = opActive && (phase == opLat);
    expAns   = (opActive && phase >= opLat) ? opAns : lastAns;
    if (ans_ready) readyCount++;
    checkOutput("cycle busy", int'(busy), int'(expBusy));
    checkOutput("cycle ans_ready", int'(ans_ready), int'(expReady));
    checkOutput("cycle ans", int'(ans), expAns);
  end

  task automatic waitIdle();
    int i;
    @(negedge clk);
    for (i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) checkOutput("idle timeout", 1, 0);
  endtask

  task automatic applyStimulus(input string name, input logic [15:0] x, input logic [7:0] y,
                               input int expAns, input int expLat);
    int cnt;
    bit seen;
    waitIdle();
    the_x = x;
    the_y = y;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ans_ready) seen = 1'b1;
    end
    if (!seen) checkOutput({name, " ready timeout"}, 0, 1);
    checkOutput({name, " latency"}, cnt, expLat);
    checkOutput({name, " ans"}, int'(ans), expAns);
  endtask

  initial begin
    int rc0;
    checkOutput("model x=0 y=8", acosModel(16'd0, 8'd8), 25736);
    checkOutput("model x=1.0 y=8", acosModel(16'd16384, 8'd8), 3283);
    checkOutput("model x=-1.0 y=8", acosModel(16'hC000, 8'd8), 48189);
    checkOutput("model x=0.5 y=1", acosModel(16'd8192, 8'd1), 17544);
    checkOutput("model x=0.5 y=2", acosModel(16'd8192, 8'd2), 17203);
    checkOutput("model x=20000 y=8", acosModel(16'd20000, 8'd8), 3283);
    checkOutput("model latency y=200", latModel(8'd200), 18);

    repeat (3) @(negedge clk);
    checkOutput("reset ans", int'(ans), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset ans_ready", int'(ans_ready), 0);
    rst = 1'b1;

    applyStimulus("zero", 16'd0, 8'd8, 25736, 18);
    applyStimulus("pos full", 16'd16384, 8'd8, 3283, 18);
    applyStimulus("neg full", 16'hC000, 8'd8, 48189, 18);
    applyStimulus("clamp", 16'd20000, 8'd8, 3283, 18);
    applyStimulus("half n1", 16'd8192, 8'd1, 17544, 4);
    applyStimulus("half n2", 16'd8192, 8'd2, 17203, 6);
    applyStimulus("half n200", 16'd8192, 8'd200, acosModel(16'd8192, 8'd8), 18);
    applyStimulus("zero terms", 16'd12345, 8'd0, 25736, 3);

    // Restart attempt and operand change while the first operation is in MAC.
    waitIdle();
    rc0 = readyCount;
    the_x = 16'd8192;
    the_y = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    the_x = 16'd16384;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    checkOutput("busy restart ans", int'(ans), 17203);
    checkOutput("busy restart readies", readyCount - rc0, 1);

    // Start held high: operations at edges 0, 6 and 12.
    waitIdle();
    rc0 = readyCount;
    the_x = 16'd8192;
    the_y = 8'd1;
    start = 1'b1;
    repeat (14) @(negedge clk);
    start = 1'b0;
    waitIdle();
    checkOutput("back-to-back readies", readyCount - rc0, 3);
    checkOutput("back-to-back ans", int'(ans), 17544);

    // Reset while the series is in a POW step.
    waitIdle();
    the_x = 16'd16384;
    the_y = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort ans", int'(ans), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort ans_ready", int'(ans_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    rc0 = readyCount;
    repeat (25) @(negedge clk);
    checkOutput("abort readies", readyCount - rc0, 0);
    applyStimulus("after abort", 16'd8192, 8'd1, 17544, 4);

    waitIdle();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
